// File: rtl/safer_alert_reporter_if.sv
// Byte-stream link from the alert reporter to the cockpit display / data-link transmitter.
// The reporter is the master; the downstream consumer drives tx_ready.
interface safer_alert_reporter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/safer_alert_reporter.sv
// Serialises SAFER risk-core status into 7-byte framed messages and latches critical alerts
// until the crew acknowledges them. Frames go out on change, new critical latch, heartbeat and boot.
module safer_alert_reporter #(
    parameter int unsigned HEARTBEAT_CYCLES = 1000000,
    parameter logic [7:0]  SYNC_BYTE        = 8'hA5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    risk_level,
    input  logic [15:0]                   alert_flags,
    input  logic                          system_ok,
    input  logic [3:0]                    crit_ack,
    safer_alert_reporter_if.master        tx,
    output logic [3:0]                    crit_latched,
    output logic                          busy,
    output logic [7:0]                    seq_num
);

    localparam int unsigned HB_W = $clog2(HEARTBEAT_CYCLES);
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [3:0]        crit_latched_next;
    logic              crit_rise;
    logic              pending;
    logic              boot_pending;
    logic [HB_W-1:0]   hb_cnt;
    logic [7:0]        snap_risk;
    logic [15:0]       snap_flags;
    logic              snap_ok;
    logic [7:0]        snap_status;
    logic [2:0]        byte_idx;
    logic              change;
    logic              trigger;
    logic              frame_start;
    logic              handshake;
    logic [7:0]        checksum;
    logic [7:0]        frame_byte;

    // Set wins over acknowledge, so a still-asserted critical flag can never be cleared.
    assign crit_latched_next = alert_flags[15:12] | (crit_latched & ~crit_ack);
    assign crit_rise         = |(crit_latched_next & ~crit_latched);

    assign change    = {risk_level, alert_flags, system_ok} != {snap_risk, snap_flags, snap_ok};
    assign trigger   = boot_pending | pending | change | (hb_cnt == HB_LAST);
    assign handshake = (state == SEND) && tx.tx_ready;

    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_next  = SEND;
                    frame_start = 1'b1;
                end
            end
            SEND: begin
                if (tx.tx_ready && (byte_idx == 3'd6)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crit_latched <= 4'b0000;
            pending      <= 1'b0;
            boot_pending <= 1'b1;
            hb_cnt       <= '0;
            snap_risk    <= 8'h00;
            snap_flags   <= 16'h0000;
            snap_ok      <= 1'b0;
            snap_status  <= 8'h00;
            byte_idx     <= 3'd0;
            seq_num      <= 8'h00;
        end else begin
            crit_latched <= crit_latched_next;
            pending      <= frame_start ? 1'b0 : (pending | crit_rise);
            if (frame_start) begin
                snap_risk    <= risk_level;
                snap_flags   <= alert_flags;
                snap_ok      <= system_ok;
                snap_status  <= {system_ok, 3'b000, crit_latched_next};
                boot_pending <= 1'b0;
                hb_cnt       <= '0;
                byte_idx     <= 3'd0;
            end else if (hb_cnt != HB_LAST) begin
                hb_cnt <= hb_cnt + 1'b1;
            end
            // The byte index parks on 6 after the final handshake until the next frame reloads it.
            if (handshake) begin
                if (byte_idx == 3'd6) begin
                    seq_num <= seq_num + 8'd1;
                end else begin
                    byte_idx <= byte_idx + 3'd1;
                end
            end
        end
    end

    assign checksum = SYNC_BYTE ^ seq_num ^ snap_status ^ snap_risk ^ snap_flags[15:8] ^ snap_flags[7:0];

    always_comb begin
        frame_byte = 8'h00;
        case (byte_idx)
            3'd0:    frame_byte = SYNC_BYTE;
            3'd1:    frame_byte = seq_num;
            3'd2:    frame_byte = snap_status;
            3'd3:    frame_byte = snap_risk;
            3'd4:    frame_byte = snap_flags[15:8];
            3'd5:    frame_byte = snap_flags[7:0];
            3'd6:    frame_byte = checksum;
            default: frame_byte = 8'h00;
        endcase
    end

    assign busy        = (state == SEND);
    assign tx.tx_valid = busy;
    assign tx.tx_data  = busy ? frame_byte : 8'h00;
    assign tx.tx_last  = busy && (byte_idx == 3'd6);

endmodule

// File: tb/tb_safer_alert_reporter.sv
// Self-checking bench for safer_alert_reporter: directed scenarios plus randomized traffic,
// all compared against a frame-queue reference model.
module tb_safer_alert_reporter;

    localparam int HB = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  risk_level = 8'h00;
    logic [15:0] alert_flags = 16'h0000;
    logic        system_ok = 1'b0;
    logic [3:0]  crit_ack = 4'b0000;
    logic [3:0]  crit_latched;
    logic        busy;
    logic [7:0]  seq_num;

    safer_alert_reporter_if tx_if();

    safer_alert_reporter #(
        .HEARTBEAT_CYCLES(HB),
        .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .risk_level(risk_level),
        .alert_flags(alert_flags),
        .system_ok(system_ok),
        .crit_ack(crit_ack),
        .tx(tx_if.master),
        .crit_latched(crit_latched),
        .busy(busy),
        .seq_num(seq_num)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycle = 0;

    // Reference model: a frame is built as a byte queue when it starts and drained on handshakes.
    logic        m_boot;
    logic        m_pending;
    logic [3:0]  m_lat;
    logic [24:0] m_snap;
    int          m_hb;
    logic [7:0]  m_seq;
    logic [7:0]  m_frame[$];

    logic [9:0]  obs_tx, exp_tx;
    logic [12:0] obs_aux, exp_aux;

    task automatic model_reset();
        m_boot    = 1'b1;
        m_pending = 1'b0;
        m_lat     = 4'b0000;
        m_snap    = '0;
        m_hb      = 0;
        m_seq     = 8'h00;
        m_frame.delete();
    endtask

    task automatic model_step();
        logic [3:0] lat_n;
        logic [7:0] fr[7];
        logic [7:0] chk;
        bit         started;
        started = 0;
        for (int i = 0; i < 4; i++) begin
            if (alert_flags[12+i])  lat_n[i] = 1'b1;
            else if (crit_ack[i])   lat_n[i] = 1'b0;
            else                    lat_n[i] = m_lat[i];
        end
        if (m_frame.size() == 0) begin
            if (m_boot || m_pending || ({risk_level, alert_flags, system_ok} != m_snap) || (m_hb == HB - 1)) begin
                fr = '{8'hA5, m_seq, {system_ok, 3'b000, lat_n}, risk_level, alert_flags[15:8], alert_flags[7:0], 8'h00};
                chk = 8'h00;
                for (int k = 0; k < 6; k++) chk = chk ^ fr[k];
                fr[6] = chk;
                for (int k = 0; k < 7; k++) m_frame.push_back(fr[k]);
                m_snap  = {risk_level, alert_flags, system_ok};
                m_boot  = 1'b0;
                started = 1;
            end
        end else if (tx_if.tx_ready) begin
            void'(m_frame.pop_front());
            if (m_frame.size() == 0) m_seq = m_seq + 8'd1;
        end
        if (started)            m_hb = 0;
        else if (m_hb < HB - 1) m_hb = m_hb + 1;
        m_pending = started ? 1'b0 : (m_pending | (|(lat_n & ~m_lat)));
        m_lat = lat_n;
    endtask

    // Advances one clock and samples DUT and model outputs at the following falling edge.
    task automatic tick();
        logic v;
        model_step();
        @(posedge clk);
        @(negedge clk);
        cycle++;
        v = (m_frame.size() != 0);
        exp_tx  = {v, v && (m_frame.size() == 1), v ? m_frame[0] : 8'h00};
        exp_aux = {v, m_lat, m_seq};
        obs_tx  = {tx_if.tx_valid, tx_if.tx_last, tx_if.tx_data};
        obs_aux = {busy, crit_latched, seq_num};
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tx_if.tx_ready = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        obs_tx  = {tx_if.tx_valid, tx_if.tx_last, tx_if.tx_data};
        obs_aux = {busy, crit_latched, seq_num};
        checks++;
        if (obs_tx !== 10'h000) begin errors++; $display("[TB] FAIL reset_tx got=%h exp=%h", obs_tx, 10'h000); end
        checks++;
        if (obs_aux !== 13'h0000) begin errors++; $display("[TB] FAIL reset_aux got=%h exp=%h", obs_aux, 13'h0000); end
        rst_n = 1'b1;
    endtask

    task automatic test_boot_frame();
        logic [7:0] boot_bytes[7];
        boot_bytes = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hA5};
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if (obs_tx !== {1'b1, (k == 6), boot_bytes[k]}) begin
                errors++; $display("[TB] FAIL boot_byte%0d got=%h exp=%h", k, obs_tx, {1'b1, (k == 6), boot_bytes[k]});
            end
            checks++;
            if (obs_tx !== exp_tx) begin errors++; $display("[TB] FAIL boot_model @%0d got=%h exp=%h", cycle, obs_tx, exp_tx); end
        end
        tick();
        checks++;
        if (seq_num !== 8'h01 || tx_if.tx_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL boot_seq got seq=%h valid=%b exp seq=01 valid=0", seq_num, tx_if.tx_valid);
        end
    endtask

    task automatic test_crit_change();
        logic [7:0] want[7];
        want = '{8'hA5, 8'h01, 8'h88, 8'h40, 8'h80, 8'h00, 8'hEC};
        risk_level  = 8'h40;
        alert_flags = 16'h8000;
        system_ok   = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            checks++;
            if (obs_tx !== {1'b1, (k == 6), want[k]}) begin
                errors++; $display("[TB] FAIL crit_byte%0d got=%h exp=%h", k, obs_tx, {1'b1, (k == 6), want[k]});
            end
            checks++;
            if (obs_aux !== exp_aux) begin errors++; $display("[TB] FAIL crit_aux @%0d got=%h exp=%h", cycle, obs_aux, exp_aux); end
        end
        tick();
        checks++;
        if (crit_latched !== 4'b1000) begin errors++; $display("[TB] FAIL crit_latch got=%b exp=1000", crit_latched); end
    endtask

    task automatic test_ack();
        int budget;
        crit_ack = 4'b1000;
        tick();
        crit_ack = 4'b0000;
        checks++;
        if (crit_latched !== 4'b1000) begin errors++; $display("[TB] FAIL ack_held got=%b exp=1000", crit_latched); end
        alert_flags = 16'h0000;
        tick();
        checks++;
        if (obs_tx !== exp_tx) begin errors++; $display("[TB] FAIL ack_clearframe @%0d got=%h exp=%h", cycle, obs_tx, exp_tx); end
        budget = 30;
        while (m_frame.size() != 0 && budget > 0) begin
            tick();
            budget--;
            checks++;
            if (obs_tx !== exp_tx) begin errors++; $display("[TB] FAIL ack_frame @%0d got=%h exp=%h", cycle, obs_tx, exp_tx); end
        end
        checks++;
        if (budget == 0) begin errors++; $display("[TB] FAIL ack_timeout got=busy exp=idle"); end
        crit_ack = 4'b1000;
        tick();
        crit_ack = 4'b0000;
        checks++;
        if (crit_latched !== 4'b0000) begin errors++; $display("[TB] FAIL ack_clear got=%b exp=0000", crit_latched); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (tx_if.tx_valid !== 1'b0) begin errors++; $display("[TB] FAIL ack_noframe got valid=%b exp=0", tx_if.tx_valid); end
            tick();
            checks++;
            if (obs_aux !== exp_aux) begin errors++; $display("[TB] FAIL ack_aux @%0d got=%h exp=%h", cycle, obs_aux, exp_aux); end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] got[$];
        logic [9:0] prev_tx;
        logic       rdy;
        int         frames;
        int         budget;
        got.delete();
        frames  = 0;
        budget  = 100;
        prev_tx = obs_tx;
        risk_level = 8'h55;
        for (int i = 0; budget > 0 && frames < 2; i++) begin
            budget--;
            rdy = (i % 2) == 1;
            tx_if.tx_ready = rdy;
            if (i == 4) risk_level = 8'h66;
            if (prev_tx[9] && rdy) begin
                got.push_back(prev_tx[7:0]);
                if (prev_tx[8]) frames++;
            end
            tick();
            checks++;
            if (obs_tx !== exp_tx) begin errors++; $display("[TB] FAIL bp_tx @%0d got=%h exp=%h", cycle, obs_tx, exp_tx); end
            if (prev_tx[9] && !rdy) begin
                checks++;
                if (obs_tx !== prev_tx) begin errors++; $display("[TB] FAIL bp_stable @%0d got=%h exp=%h", cycle, obs_tx, prev_tx); end
            end
            prev_tx = obs_tx;
        end
        tx_if.tx_ready = 1'b1;
        checks++;
        if (got.size() != 14) begin
            errors++; $display("[TB] FAIL bp_count got=%0d exp=14", got.size());
        end else begin
            checks++;
            if (got[3] !== 8'h55 || got[10] !== 8'h66 || got[0] !== 8'hA5 || got[7] !== 8'hA5) begin
                errors++; $display("[TB] FAIL bp_bytes got=%h,%h,%h,%h exp=a5,55,a5,66", got[0], got[3], got[7], got[10]);
            end
        end
    endtask

    task automatic test_heartbeat();
        int         starts;
        int         last_start;
        logic [7:0] seq0;
        logic       prev_valid;
        tx_if.tx_ready = 1'b1;
        starts     = 0;
        last_start = -1;
        seq0       = 8'h00;
        prev_valid = tx_if.tx_valid;
        for (int i = 0; i < 5000 && starts < 258; i++) begin
            tick();
            checks++;
            if (obs_tx !== exp_tx || obs_aux !== exp_aux) begin
                errors++; $display("[TB] FAIL hb_model @%0d got=%h/%h exp=%h/%h", cycle, obs_tx, obs_aux, exp_tx, exp_aux);
            end
            if (obs_tx[9] && !prev_valid) begin
                if (last_start >= 0) begin
                    checks++;
                    if (cycle - last_start != HB) begin errors++; $display("[TB] FAIL hb_gap got=%0d exp=%0d", cycle - last_start, HB); end
                end
                if (starts == 1) seq0 = seq_num;
                if (starts == 257) begin
                    checks++;
                    if (seq_num !== seq0) begin errors++; $display("[TB] FAIL hb_wrap got=%h exp=%h", seq_num, seq0); end
                end
                last_start = cycle;
                starts++;
            end
            prev_valid = obs_tx[9];
        end
        checks++;
        if (starts < 258) begin errors++; $display("[TB] FAIL hb_starts got=%0d exp=258", starts); end
    endtask

    task automatic test_reset_mid_frame();
        int budget;
        risk_level = 8'h77;
        budget = 40;
        tick();
        while (!(m_frame.size() == 4) && budget > 0) begin
            tick();
            budget--;
        end
        checks++;
        if (obs_tx !== exp_tx || m_frame.size() != 4) begin
            errors++; $display("[TB] FAIL rstmid_byte3 got=%h exp=%h", obs_tx, exp_tx);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (tx_if.tx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL rstmid_abort got valid=%b busy=%b exp 0/0", tx_if.tx_valid, busy);
        end
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (obs_tx !== exp_tx || obs_aux !== exp_aux) begin
                errors++; $display("[TB] FAIL rstmid_boot @%0d got=%h/%h exp=%h/%h", cycle, obs_tx, obs_aux, exp_tx, exp_aux);
            end
            if (k == 1) begin
                checks++;
                if (obs_tx !== 10'h200) begin errors++; $display("[TB] FAIL rstmid_seq got=%h exp=200", obs_tx); end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) risk_level = 8'($urandom);
            if ($urandom_range(0, 15) == 0) alert_flags[11:0] = 12'($urandom);
            alert_flags[15:12] = ($urandom_range(0, 11) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 31) == 0) system_ok = ~system_ok;
            crit_ack = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            tx_if.tx_ready = ($urandom_range(0, 3) != 0);
            tick();
            checks++;
            if (obs_tx !== exp_tx) begin errors++; $display("[TB] FAIL rand_tx @%0d got=%h exp=%h", cycle, obs_tx, exp_tx); end
            checks++;
            if (obs_aux !== exp_aux) begin errors++; $display("[TB] FAIL rand_aux @%0d got=%h exp=%h", cycle, obs_aux, exp_aux); end
        end
    endtask

    initial begin
        tx_if.tx_ready = 1'b1;
        test_reset();
        test_boot_frame();
        test_crit_change();
        test_ack();
        test_backpressure();
        test_heartbeat();
        test_reset_mid_frame();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule

// File: doc/safer_alert_reporter.md
Name: safer_alert_reporter

Overview:
Consumer-side counterpart of the SAFER risk core. It takes the core's risk_level, alert_flags and system_ok outputs and serialises them into framed byte messages for the cockpit display / data-link transmitter, using a valid/ready byte stream. It latches critical alerts until the crew acknowledges them. It sends frames on input change, on a new critical latch, on a heartbeat timeout, and once after reset.

Parameters:
HEARTBEAT_CYCLES, 1000000, idle cycles after a frame start before a heartbeat frame is forced (>=16)
SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
risk_level  input  8  combined risk from SAFER core
alert_flags  input  16  [15:12] critical flight/env/maint/personnel; [11:0] warnings
system_ok  input  1  core status
crit_ack  input  4  per-bit crew acknowledge of crit_latched
tx_data  output  8  frame byte
tx_valid  output  1  tx_data valid
tx_last  output  1  marks final byte of frame
tx_ready  input  1  downstream accepts byte when tx_valid && tx_ready
crit_latched  output  4  sticky critical alerts
busy  output  1  frame in progress (state SEND)
seq_num  output  8  sequence number of the next frame

Behaviour:
- Reset values: tx_data 0, tx_valid 0, tx_last 0, crit_latched 0, busy 0, seq_num 0, heartbeat counter 0, snapshot registers 0, boot_pending 1.
- crit_latched[i]:
  - Set in any cycle where alert_flags[12+i] = 1.
  - Cleared when crit_ack[i] = 1 and alert_flags[12+i] = 0 in the same cycle.
  - If ack and flag are both high, the bit stays set: set wins.
  - Latching is independent of the FSM state.
- crit_rise: any bit of crit_latched going 0->1 sets a pending flag. The flag clears when the next frame starts.
- FSM states: IDLE, SEND.
- IDLE -> SEND when any trigger is true in an IDLE cycle:
  - boot_pending.
  - pending (crit_rise).
  - change: {risk_level, alert_flags, system_ok} differs from the last snapshot.
  - heartbeat counter == HEARTBEAT_CYCLES-1.
- On that transition cycle, all of the following happen:
  - Snapshot risk_level, alert_flags, system_ok, and STATUS = {system_ok, 3'b000, crit_latched_next}, where crit_latched_next already includes bits set this cycle.
  - Clear boot_pending and pending.
  - Reset the heartbeat counter to 0.
  - Load byte index 0.
- Latency: trigger in IDLE cycle N -> tx_valid = 1 with byte 0 in cycle N+1.
- Frame is 7 bytes, indices 0..6:
  - 0: SYNC_BYTE
  - 1: seq_num
  - 2: STATUS
  - 3: risk_level
  - 4: alert_flags[15:8]
  - 5: alert_flags[7:0]
  - 6: CHK = XOR of bytes 0..5
- All frame bytes come from the snapshot. Input changes during SEND do not alter the frame in flight. They are detected as a change on return to IDLE, because comparison is against the snapshot.
- Handshake rules:
  - tx_valid stays high for the whole of SEND.
  - tx_data and tx_last stay stable while tx_valid && !tx_ready.
  - The byte index advances only on a tx_valid && tx_ready cycle.
  - tx_last = 1 only with byte 6.
- On the byte-6 handshake:
  - tx_valid drops to 0 and state returns to IDLE.
  - seq_num increments modulo 256 (255 -> 0).
  - At least one IDLE cycle (tx_valid = 0) separates frames.
- Heartbeat counter increments every cycle in both states and saturates at HEARTBEAT_CYCLES-1. If it expires during SEND, the heartbeat frame is issued in the first IDLE cycle.
- Simultaneous triggers produce a single frame.
- tx_ready held low: the FSM stalls indefinitely with no timeout. crit_latched keeps updating.
- Reset mid-frame: the frame is aborted immediately (tx_valid 0). After release, a boot frame with seq 0 is sent.

Test Plan:
- Boot frame: release reset with all inputs 0 and tx_ready = 1 -> bytes A5,00,00,00,00,00,A5 in consecutive cycles; tx_last on the 7th; seq_num becomes 1.
- Change with critical flag: after the boot frame, drive risk_level = 40, alert_flags = 8000, system_ok = 1 -> crit_latched = 1000 and frame A5,01,88,40,80,00,EC.
- Backpressure: toggle tx_ready 1/0 every cycle during a frame -> no byte lost or duplicated, data stable while stalled, and a risk_level change mid-frame produces a second frame afterwards.
- Acknowledge: with crit_latched = 1000 and alert_flags[15] still 1, pulse crit_ack = 1000 -> stays 1000. Clear the flag, then pulse ack -> 0000, and no frame is sent for the clear.
- Heartbeat: HEARTBEAT_CYCLES = 16, inputs constant -> a frame starts every 16 cycles with seq_num incrementing. Run 256 frames -> seq wraps FF -> 00.
- Reset mid-frame: assert rst_n low at byte 3 -> tx_valid 0 asynchronously. After release, boot frame with seq 00.
